// File: rtl/sprite_fetch_arbiter_if.sv
// Sprite BRAM read port shared between the fetch arbiter (master) and the
// sprite memory (slave).
interface sprite_fetch_arbiter_if;
  logic [7:0]  o_bram_addr;
  logic        o_bram_re;
  logic [15:0] i_bram_data;

  modport master (output o_bram_addr, output o_bram_re, input i_bram_data);
  modport slave  (input o_bram_addr, input o_bram_re, output i_bram_data);
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter that fetches one 16-pixel, 4 bpp sprite row for the
// winning requester and streams it out as one nibble per cycle.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WORDS_PER_ROW = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [2*NUM_REQ-1:0]   i_sprite_id,
  input  logic [4*NUM_REQ-1:0]   i_row,
  output logic [NUM_REQ-1:0]     o_grant,
  sprite_fetch_arbiter_if.master bram,
  output logic [3:0]             o_pixel,
  output logic                   o_pixel_valid,
  output logic                   o_pixel_last,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_U0,
    S_U1,
    S_U2,
    S_U3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [1:0]         r_gnt_idx;
  logic [1:0]         r_ptr;
  logic [1:0]         r_sid;
  logic [3:0]         r_row;
  logic [1:0]         r_word;
  logic [7:0]         r_addr;
  logic [15:0]        r_shift;

  logic               w_sel_found;
  logic [1:0]         w_sel_idx;
  logic [1:0]         w_cand;
  logic               w_word_last;
  logic [1:0]         w_word_inc;
  logic [1:0]         w_sel_sid;
  logic [3:0]         w_sel_row;

  // First active requester at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_sel_found && i_req[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_word_last = (r_word == 2'(WORDS_PER_ROW - 1));
    w_word_inc  = r_word + 2'd1;
    w_sel_sid   = i_sprite_id[{w_sel_idx, 1'b0} +: 2];
    w_sel_row   = i_row[{w_sel_idx, 2'b00} +: 4];
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    o_busy           = 1'b1;
    bram.o_bram_re   = 1'b0;
    o_pixel_valid    = 1'b0;
    o_pixel_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_sel_found) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bram.o_bram_re = 1'b1;
        w_state_nxt    = S_LATCH;
      end
      S_LATCH: w_state_nxt = S_U0;
      S_U0: begin
        o_pixel_valid = 1'b1;
        w_state_nxt   = S_U1;
      end
      S_U1: begin
        o_pixel_valid = 1'b1;
        w_state_nxt   = S_U2;
      end
      S_U2: begin
        o_pixel_valid = 1'b1;
        w_state_nxt   = S_U3;
      end
      S_U3: begin
        o_pixel_valid = 1'b1;
        o_pixel_last  = w_word_last;
        w_state_nxt   = w_word_last ? S_IDLE : S_FETCH;
      end
      default: begin
        o_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    o_pixel          = o_pixel_valid ? r_shift[3:0] : '0;
    o_grant          = r_grant;
    bram.o_bram_addr = r_addr;
  end

  // The address register is loaded on the edge entering FETCH so it is
  // already valid during FETCH and holds its value everywhere else.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant   <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
      r_sid     <= '0;
      r_row     <= '0;
      r_word    <= '0;
      r_addr    <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_found) begin
            r_grant   <= NUM_REQ'(1) << w_sel_idx;
            r_gnt_idx <= w_sel_idx;
            r_sid     <= w_sel_sid;
            r_row     <= w_sel_row;
            r_word    <= '0;
            r_addr    <= {w_sel_sid, w_sel_row, 2'b00};
          end
        end
        S_LATCH: r_shift <= bram.i_bram_data;
        S_U0, S_U1, S_U2: r_shift <= {4'h0, r_shift[15:4]};
        S_U3: begin
          if (w_word_last) begin
            r_grant <= '0;
            r_ptr   <= r_gnt_idx + 2'd1;
          end else begin
            r_word <= w_word_inc;
            r_addr <= {r_sid, r_row, w_word_inc};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomised and directed bench for sprite_fetch_arbiter, checked against a
// row-position reference model and a BRAM model driven by the bench.
module tb_sprite_fetch_arbiter;

  logic        clk;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [7:0]  i_sprite_id;
  logic [15:0] i_row;
  logic [3:0]  o_grant;
  logic [3:0]  o_pixel;
  logic        o_pixel_valid;
  logic        o_pixel_last;
  logic        o_busy;

  sprite_fetch_arbiter_if bif ();

  sprite_fetch_arbiter #(.NUM_REQ(4), .WORDS_PER_ROW(4)) dut (
    .i_Clk        (clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_sprite_id  (i_sprite_id),
    .i_row        (i_row),
    .o_grant      (o_grant),
    .bram         (bif.master),
    .o_pixel      (o_pixel),
    .o_pixel_valid(o_pixel_valid),
    .o_pixel_last (o_pixel_last),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] salt;

  // Reference model: position within the current row (0 = idle, 1..24).
  int         m_k, m_ptr, m_idx;
  logic [1:0] m_sid;
  logic [3:0] m_row;
  logic [7:0] m_last_addr;

  // Observations for directed checks.
  logic [3:0] gq[$];
  int         glen[$];
  int         gaps[$];
  logic [3:0] pix[$];
  logic [7:0] aq[$];
  logic [3:0] prev_g;
  int         run, gap, last_idx, act;
  bit         have_g;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return (16'(a) + 16'h1230) ^ salt;
  endfunction

  function automatic logic [3:0] exp_pix(input logic [7:0] base, input int i);
    logic [15:0] d;
    d = 16'h1230 + 16'(base) + 16'(i / 4);
    return 4'(d >> (4 * (i % 4)));
  endfunction

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < 4; i++)
      if (req[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_k = 0; m_ptr = 0; m_idx = 0; m_sid = '0; m_row = '0; m_last_addr = '0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [7:0] sid, input logic [15:0] row);
    int idx;
    if (m_k == 0) begin
      idx = pick(req, m_ptr);
      if (idx >= 0) begin
        m_idx = idx;
        m_sid = sid[2*idx +: 2];
        m_row = row[4*idx +: 4];
        m_k   = 1;
      end
    end else if (m_k == 24) begin
      m_last_addr = {m_sid, m_row, 2'd3};
      m_ptr = (m_idx + 1) % 4;
      m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic clear_obs();
    gq.delete(); glen.delete(); gaps.delete(); pix.delete(); aq.delete();
    run = 0; gap = 0; last_idx = -1; act = 0; have_g = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 16'(o_grant), 16'h0);
    chk({tag, "_re"},    16'(bif.o_bram_re), 16'h0);
    chk({tag, "_addr"},  16'(bif.o_bram_addr), 16'h0);
    chk({tag, "_pix"},   16'(o_pixel), 16'h0);
    chk({tag, "_valid"}, 16'(o_pixel_valid), 16'h0);
    chk({tag, "_last"},  16'(o_pixel_last), 16'h0);
    chk({tag, "_busy"},  16'(o_busy), 16'h0);
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic cycle(input logic [3:0] req, input logic [7:0] sid, input logic [15:0] row);
    logic [3:0] eg, ep;
    logic       eb, ere, ev, el;
    logic [7:0] ea;
    logic       re_s;
    logic [7:0] a_s;
    int w, p;
    i_req = req; i_sprite_id = sid; i_row = row;
    #1;
    if (m_k == 0) begin
      eg = '0; eb = 0; ere = 0; ea = m_last_addr; ev = 0; ep = '0; el = 0;
    end else begin
      w  = (m_k - 1) / 6;
      p  = (m_k - 1) % 6;
      eg = 4'(1 << m_idx);
      eb = 1;
      ere = (p == 0);
      ea = {m_sid, m_row, 2'(w)};
      ev = (p >= 2);
      ep = ev ? 4'(mem_word(ea) >> (4 * (p - 2))) : 4'h0;
      el = (m_k == 24);
    end
    chk("grant", 16'(o_grant), 16'(eg));
    chk("busy",  16'(o_busy), 16'(eb));
    chk("re",    16'(bif.o_bram_re), 16'(ere));
    chk("addr",  16'(bif.o_bram_addr), 16'(ea));
    chk("valid", 16'(o_pixel_valid), 16'(ev));
    chk("pixel", 16'(o_pixel), 16'(ep));
    chk("last",  16'(o_pixel_last), 16'(el));

    if (o_grant != 0) begin
      if (prev_g == 0) begin
        gq.push_back(o_grant);
        if (have_g) gaps.push_back(gap);
        have_g = 1; run = 0; gap = 0;
      end
      run++;
    end else begin
      if (prev_g != 0) glen.push_back(run);
      gap++;
    end
    prev_g = o_grant;
    if (o_pixel_valid) begin
      if (o_pixel_last) last_idx = pix.size();
      pix.push_back(o_pixel);
    end
    if (bif.o_bram_re) aq.push_back(bif.o_bram_addr);
    if (bif.o_bram_re || o_busy || o_pixel_valid) act++;

    re_s = bif.o_bram_re;
    a_s  = bif.o_bram_addr;
    @(posedge clk);
    model_step(req, sid, row);
    #1;
    bif.i_bram_data = re_s ? mem_word(a_s) : 16'($urandom);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'h0, 8'($urandom), 16'($urandom));
  endtask

  task automatic pulse_reset(input string tag);
    i_reset = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    i_reset = 1'b0;
    prev_g = '0;
  endtask

  initial begin
    i_reset = 1'b1; i_req = '0; i_sprite_id = '0; i_row = '0;
    bif.i_bram_data = '0; salt = '0; prev_g = '0;
    model_reset();
    clear_obs();
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;

    // Single row for requester 1, sprite 3, row 5.
    clear_obs();
    cycle(4'b0010, 8'b0000_1100, 16'h0050);
    idle(30);
    chk("d36_npix", 16'(pix.size()), 16'd16);
    for (int i = 0; i < 16; i++)
      chk("d36_pix", (i < pix.size()) ? 16'(pix[i]) : 16'hFFFF, 16'(exp_pix(8'hD4, i)));
    chk("d36_naddr", 16'(aq.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      chk("d36_addr", (i < aq.size()) ? 16'(aq[i]) : 16'hFFFF, 16'(8'hD4 + 8'(i)));
    chk("d36_lastidx", 16'(last_idx), 16'd15);
    chk("d36_gnt", (gq.size() > 0) ? 16'(gq[0]) : 16'hFFFF, 16'h0002);
    chk("d36_glen", (glen.size() > 0) ? 16'(glen[0]) : 16'hFFFF, 16'd24);

    // All four requesting: round robin from pointer 0.
    pulse_reset("rst37");
    clear_obs();
    for (int i = 0; i < 100; i++) cycle(4'b1111, 8'($urandom), 16'($urandom));
    idle(5);
    chk("d37_ngnt", 16'(gq.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk("d37_gnt", (i < gq.size()) ? 16'(gq[i]) : 16'hFFFF, 16'(1 << i));
      chk("d37_glen", (i < glen.size()) ? 16'(glen[i]) : 16'hFFFF, 16'd24);
    end
    for (int i = 0; i < 3; i++)
      chk("d37_gap", (i < gaps.size()) ? 16'(gaps[i]) : 16'hFFFF, 16'd1);

    // Pointer moved to 2, then requesters 0 and 1: wrap to 0 first.
    cycle(4'b0010, 8'($urandom), 16'($urandom));
    idle(30);
    clear_obs();
    for (int i = 0; i < 50; i++) cycle(4'b0011, 8'($urandom), 16'($urandom));
    idle(5);
    chk("d38_ngnt", 16'(gq.size()), 16'd2);
    chk("d38_gnt0", (gq.size() > 0) ? 16'(gq[0]) : 16'hFFFF, 16'h0001);
    chk("d38_gnt1", (gq.size() > 1) ? 16'(gq[1]) : 16'hFFFF, 16'h0002);

    // Asynchronous reset during U1 of word 2.
    cycle(4'b0001, 8'($urandom), 16'($urandom));
    for (int i = 0; i < 40 && m_k != 16; i++) cycle(4'h0, 8'($urandom), 16'($urandom));
    chk("d39_reach_u1", 16'(m_k), 16'd16);
    pulse_reset("d39_rst");
    clear_obs();
    idle(20);
    chk("d39_nopix", 16'(pix.size()), 16'd0);
    clear_obs();
    cycle(4'b1000, 8'($urandom), 16'($urandom));
    idle(30);
    chk("d39_gnt", (gq.size() > 0) ? 16'(gq[0]) : 16'hFFFF, 16'h0008);

    // Request dropped after one cycle, address inputs scrambled mid-row.
    clear_obs();
    cycle(4'b0100, 8'b0010_0000, 16'h0A00);
    idle(30);
    chk("d40_npix", 16'(pix.size()), 16'd16);
    for (int i = 0; i < 16; i++)
      chk("d40_pix", (i < pix.size()) ? 16'(pix[i]) : 16'hFFFF, 16'(exp_pix(8'hA8, i)));

    // Long idle stretch.
    clear_obs();
    idle(100);
    chk("d41_active", 16'(act), 16'd0);

    // Random traffic with a scrambled BRAM image.
    salt = 16'($urandom);
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
            8'($urandom), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
